// File: rtl/fifo_rate_gen_fifo.sv
// FIFO exerciser: periodic write/read strobes drive an incrementing data source
// through a circular FIFO, with fill level and saturating overflow/underflow counters.
module fifo_rate_gen_fifo #(
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned DEPTH_LOG2    = 3,
  parameter int unsigned WR_EN_PERIOD  = 100,
  parameter int unsigned RD_EN_PERIOD  = 35,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     kill,
  input  logic                     run,
  output logic [DATA_WIDTH-1:0]    data_read,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH_LOG2:0]      level,
  output logic [ERR_CNT_WIDTH-1:0] ovf_cnt,
  output logic [ERR_CNT_WIDTH-1:0] udf_cnt
);

  localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W    = DEPTH_LOG2 + 1;
  localparam int unsigned WR_CNT_W = (WR_EN_PERIOD > 1) ? $clog2(WR_EN_PERIOD) : 1;
  localparam int unsigned RD_CNT_W = (RD_EN_PERIOD > 1) ? $clog2(RD_EN_PERIOD) : 1;

  localparam logic [WR_CNT_W-1:0] WR_LAST = WR_CNT_W'(WR_EN_PERIOD - 1);
  localparam logic [RD_CNT_W-1:0] RD_LAST = RD_CNT_W'(RD_EN_PERIOD - 1);

  // Reject unsupported parameterisations at elaboration.
  if (WR_EN_PERIOD == 0) begin : g_bad_wr_period
    $error("fifo_rate_gen_fifo: WR_EN_PERIOD must be >= 1");
  end
  if (RD_EN_PERIOD == 0) begin : g_bad_rd_period
    $error("fifo_rate_gen_fifo: RD_EN_PERIOD must be >= 1");
  end
  if (DEPTH_LOG2 == 0) begin : g_bad_depth
    $error("fifo_rate_gen_fifo: DEPTH_LOG2 must be >= 1");
  end

  logic [WR_CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [RD_CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0]    gen_q, gen_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0]    data_read_q, data_read_d;
  logic                     data_valid_q, data_valid_d;
  logic [ERR_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] udf_cnt_q, udf_cnt_d;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

  logic wr_stb_c, rd_stb_c;
  logic wr_accept_c, rd_accept_c;
  logic full_c, empty_c;

  // Strobe generators: count 0..PERIOD-1 while running, strobe and wrap at the top.
  always_comb begin
    wr_stb_c = 1'b0;
    wr_cnt_d = '0;
    if (run) begin
      if (wr_cnt_q == WR_LAST) begin
        wr_stb_c = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_stb_c = 1'b0;
    rd_cnt_d = '0;
    if (run) begin
      if (rd_cnt_q == RD_LAST) begin
        rd_stb_c = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
      end
    end
  end

  // Extra pointer MSB separates the full and empty cases of equal RAM addresses.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  // No bypass: a read sees only words already stored before this edge.
  assign rd_accept_c = rd_stb_c && !empty_c;
  assign wr_accept_c = wr_stb_c && (!full_c || rd_accept_c);

  // FIFO bookkeeping, data source and error counters.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    gen_d        = gen_q;
    level_d      = level_q;
    data_read_d  = data_read_q;
    data_valid_d = 1'b0;
    ovf_cnt_d    = ovf_cnt_q;
    udf_cnt_d    = udf_cnt_q;

    if (wr_accept_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      gen_d    = gen_q + DATA_WIDTH'(1);
    end else if (wr_stb_c && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + ERR_CNT_WIDTH'(1);
    end

    if (rd_accept_c) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      data_read_d  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      data_valid_d = 1'b1;
    end else if (rd_stb_c && (udf_cnt_q != '1)) begin
      udf_cnt_d = udf_cnt_q + ERR_CNT_WIDTH'(1);
    end

    case ({wr_accept_c, rd_accept_c})
      2'b10:   level_d = level_q + PTR_W'(1);
      2'b01:   level_d = level_q - PTR_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      gen_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_read_q  <= '0;
      data_valid_q <= 1'b0;
      ovf_cnt_q    <= '0;
      udf_cnt_q    <= '0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      gen_q        <= gen_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_read_q  <= data_read_d;
      data_valid_q <= data_valid_d;
      ovf_cnt_q    <= ovf_cnt_d;
      udf_cnt_q    <= udf_cnt_d;
    end
  end

  // Storage array carries no reset; its content is only observed after a write.
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= gen_q;
    end
  end

  assign data_read  = data_read_q;
  assign data_valid = data_valid_q;
  assign full       = full_c;
  assign empty      = empty_c;
  assign level      = level_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign udf_cnt    = udf_cnt_q;

endmodule

// File: tb/tb_fifo_rate_gen_fifo.sv
// Directed bench for fifo_rate_gen_fifo: five instances cover equal, write-fast,
// read-fast, simultaneous-at-full and counter-saturation configurations.
module tb_fifo_rate_gen_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: WR=4 RD=4
  logic kill_a = 1'b0, run_a = 1'b1;
  logic [11:0] dr_a; logic dv_a, full_a, empty_a; logic [3:0] lvl_a; logic [15:0] ovf_a, udf_a;
  // B: WR=2 RD=5
  logic kill_b = 1'b0, run_b = 1'b1;
  logic [11:0] dr_b; logic dv_b, full_b, empty_b; logic [3:0] lvl_b; logic [15:0] ovf_b, udf_b;
  // C: WR=1 RD=3
  logic kill_c = 1'b0, run_c = 1'b1;
  logic [11:0] dr_c; logic dv_c, full_c, empty_c; logic [3:0] lvl_c; logic [15:0] ovf_c, udf_c;
  // D: WR=1 RD=100, 2-bit error counters
  logic kill_d = 1'b0, run_d = 1'b1;
  logic [11:0] dr_d; logic dv_d, full_d, empty_d; logic [3:0] lvl_d; logic [1:0] ovf_d, udf_d;
  // E: WR=5 RD=2
  logic kill_e = 1'b0, run_e = 1'b1;
  logic [11:0] dr_e; logic dv_e, full_e, empty_e; logic [3:0] lvl_e; logic [15:0] ovf_e, udf_e;

  fifo_rate_gen_fifo #(.DATA_WIDTH(12), .DEPTH_LOG2(3), .WR_EN_PERIOD(4), .RD_EN_PERIOD(4),
                       .ERR_CNT_WIDTH(16)) u_a (
    .clk(clk), .kill(kill_a), .run(run_a), .data_read(dr_a), .data_valid(dv_a),
    .full(full_a), .empty(empty_a), .level(lvl_a), .ovf_cnt(ovf_a), .udf_cnt(udf_a));

  fifo_rate_gen_fifo #(.DATA_WIDTH(12), .DEPTH_LOG2(3), .WR_EN_PERIOD(2), .RD_EN_PERIOD(5),
                       .ERR_CNT_WIDTH(16)) u_b (
    .clk(clk), .kill(kill_b), .run(run_b), .data_read(dr_b), .data_valid(dv_b),
    .full(full_b), .empty(empty_b), .level(lvl_b), .ovf_cnt(ovf_b), .udf_cnt(udf_b));

  fifo_rate_gen_fifo #(.DATA_WIDTH(12), .DEPTH_LOG2(3), .WR_EN_PERIOD(1), .RD_EN_PERIOD(3),
                       .ERR_CNT_WIDTH(16)) u_c (
    .clk(clk), .kill(kill_c), .run(run_c), .data_read(dr_c), .data_valid(dv_c),
    .full(full_c), .empty(empty_c), .level(lvl_c), .ovf_cnt(ovf_c), .udf_cnt(udf_c));

  fifo_rate_gen_fifo #(.DATA_WIDTH(12), .DEPTH_LOG2(3), .WR_EN_PERIOD(1), .RD_EN_PERIOD(100),
                       .ERR_CNT_WIDTH(2)) u_d (
    .clk(clk), .kill(kill_d), .run(run_d), .data_read(dr_d), .data_valid(dv_d),
    .full(full_d), .empty(empty_d), .level(lvl_d), .ovf_cnt(ovf_d), .udf_cnt(udf_d));

  fifo_rate_gen_fifo #(.DATA_WIDTH(12), .DEPTH_LOG2(3), .WR_EN_PERIOD(5), .RD_EN_PERIOD(2),
                       .ERR_CNT_WIDTH(16)) u_e (
    .clk(clk), .kill(kill_e), .run(run_e), .data_read(dr_e), .data_valid(dv_e),
    .full(full_e), .empty(empty_e), .level(lvl_e), .ovf_cnt(ovf_e), .udf_cnt(udf_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (lvl_a !== 4'd0) begin errors++; $display("FAIL rst_level_a got=%0d exp=0", lvl_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL rst_empty_a got=%0b exp=1", empty_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL rst_full_a got=%0b exp=0", full_a); end
    checks++; if (ovf_a !== 16'd0) begin errors++; $display("FAIL rst_ovf_a got=%0d exp=0", ovf_a); end
    checks++; if (udf_a !== 16'd0) begin errors++; $display("FAIL rst_udf_a got=%0d exp=0", udf_a); end
    checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL rst_valid_a got=%0b exp=0", dv_a); end
    checks++; if (dr_a !== 12'd0) begin errors++; $display("FAIL rst_data_a got=%0d exp=0", dr_a); end
    checks++; if (lvl_c !== 4'd0 || empty_c !== 1'b1 || full_c !== 1'b0)
      begin errors++; $display("FAIL rst_c level=%0d empty=%0b full=%0b exp 0/1/0", lvl_c, empty_c, full_c); end
  endtask

  task automatic test_equal_rate();
    int exp_lvl, exp_data;
    logic exp_dv;
    kill_a = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_lvl = (n >= 4) ? 1 : 0;
      exp_dv  = (n % 4 == 0) && (n >= 8);
      exp_data = n / 4 - 2;
      checks++; if (lvl_a !== 4'(exp_lvl)) begin errors++; $display("FAIL eq_level n=%0d got=%0d exp=%0d", n, lvl_a, exp_lvl); end
      checks++; if (udf_a !== 16'(exp_lvl)) begin errors++; $display("FAIL eq_udf n=%0d got=%0d exp=%0d", n, udf_a, exp_lvl); end
      checks++; if (ovf_a !== 16'd0) begin errors++; $display("FAIL eq_ovf n=%0d got=%0d exp=0", n, ovf_a); end
      checks++; if (dv_a !== exp_dv) begin errors++; $display("FAIL eq_valid n=%0d got=%0b exp=%0b", n, dv_a, exp_dv); end
      if (exp_dv) begin
        checks++; if (dr_a !== 12'(exp_data)) begin errors++; $display("FAIL eq_data n=%0d got=%0d exp=%0d", n, dr_a, exp_data); end
      end
    end
  endtask

  task automatic test_write_faster();
    int exp_next = 0;
    kill_b = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (dv_b) begin
        checks++; if (dr_b !== 12'(exp_next)) begin errors++; $display("FAIL wf_data n=%0d got=%0d exp=%0d", n, dr_b, exp_next); end
        exp_next++;
      end
      if (n == 25) begin
        checks++; if (lvl_b !== 4'd7 || full_b !== 1'b0) begin errors++; $display("FAIL wf_pre_full level=%0d full=%0b exp 7/0", lvl_b, full_b); end
      end
      if (n == 26) begin
        checks++; if (lvl_b !== 4'd8 || full_b !== 1'b1) begin errors++; $display("FAIL wf_full level=%0d full=%0b exp 8/1", lvl_b, full_b); end
      end
    end
    checks++; if (ovf_b !== 16'd52) begin errors++; $display("FAIL wf_ovf got=%0d exp=52", ovf_b); end
    checks++; if (udf_b !== 16'd0) begin errors++; $display("FAIL wf_udf got=%0d exp=0", udf_b); end
    checks++; if (lvl_b !== 4'd8) begin errors++; $display("FAIL wf_level_end got=%0d exp=8", lvl_b); end
    checks++; if (exp_next != 40) begin errors++; $display("FAIL wf_reads got=%0d exp=40", exp_next); end
    // asynchronous clear mid-stream, observed before the next edge
    kill_b = 1'b0;
    #1;
    checks++; if (lvl_b !== 4'd0 || ovf_b !== 16'd0 || dr_b !== 12'd0 || empty_b !== 1'b1)
      begin errors++; $display("FAIL wf_kill level=%0d ovf=%0d data=%0d empty=%0b exp 0/0/0/1", lvl_b, ovf_b, dr_b, empty_b); end
  endtask

  task automatic test_run_control();
    tick();
    kill_b = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 1) begin
        checks++; if (lvl_b !== 4'd0) begin errors++; $display("FAIL run_first n=1 got=%0d exp=0", lvl_b); end
      end
      if (n == 2) begin
        checks++; if (lvl_b !== 4'd1) begin errors++; $display("FAIL run_first n=2 got=%0d exp=1", lvl_b); end
      end
    end
    checks++; if (lvl_b !== 4'd5) begin errors++; $display("FAIL run_level5 got=%0d exp=5", lvl_b); end
    run_b = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++; if (lvl_b !== 4'd5 || ovf_b !== 16'd0 || udf_b !== 16'd0 || dv_b !== 1'b0)
        begin errors++; $display("FAIL run_frozen n=%0d level=%0d ovf=%0d udf=%0d valid=%0b exp 5/0/0/0", n, lvl_b, ovf_b, udf_b, dv_b); end
    end
    run_b = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      tick();
      case (m)
        1: begin checks++; if (lvl_b !== 4'd5) begin errors++; $display("FAIL run_resume m=1 got=%0d exp=5", lvl_b); end end
        2: begin checks++; if (lvl_b !== 4'd6) begin errors++; $display("FAIL run_resume m=2 got=%0d exp=6", lvl_b); end end
        4: begin checks++; if (lvl_b !== 4'd7 || dv_b !== 1'b0) begin errors++; $display("FAIL run_resume m=4 level=%0d valid=%0b exp 7/0", lvl_b, dv_b); end end
        5: begin checks++; if (lvl_b !== 4'd6 || dv_b !== 1'b1 || dr_b !== 12'd2)
             begin errors++; $display("FAIL run_resume m=5 level=%0d valid=%0b data=%0d exp 6/1/2", lvl_b, dv_b, dr_b); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_simul_full();
    int exp_ovf = 0;
    kill_c = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n >= 13 && (n % 3) != 0) exp_ovf++;
      if (n >= 11) begin
        checks++; if (lvl_c !== 4'd8 || full_c !== 1'b1) begin errors++; $display("FAIL sf_level n=%0d level=%0d full=%0b exp 8/1", n, lvl_c, full_c); end
        checks++; if (ovf_c !== 16'(exp_ovf)) begin errors++; $display("FAIL sf_ovf n=%0d got=%0d exp=%0d", n, ovf_c, exp_ovf); end
      end
      if (n % 3 == 0) begin
        checks++; if (dv_c !== 1'b1 || dr_c !== 12'(n / 3 - 1))
          begin errors++; $display("FAIL sf_read n=%0d valid=%0b data=%0d exp 1/%0d", n, dv_c, dr_c, n / 3 - 1); end
      end
    end
    checks++; if (udf_c !== 16'd0) begin errors++; $display("FAIL sf_udf got=%0d exp=0", udf_c); end
    kill_c = 1'b0;
    #1;
    checks++; if (lvl_c !== 4'd0 || ovf_c !== 16'd0 || dr_c !== 12'd0 || full_c !== 1'b0 || empty_c !== 1'b1)
      begin errors++; $display("FAIL sf_kill level=%0d ovf=%0d data=%0d full=%0b empty=%0b exp 0/0/0/0/1", lvl_c, ovf_c, dr_c, full_c, empty_c); end
  endtask

  task automatic test_read_faster();
    int exp_next = 0;
    kill_e = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      checks++; if (lvl_e > 4'd1 || ovf_e !== 16'd0) begin errors++; $display("FAIL rf_bound n=%0d level=%0d ovf=%0d exp <=1/0", n, lvl_e, ovf_e); end
      if (dv_e) begin
        checks++; if (dr_e !== 12'(exp_next)) begin errors++; $display("FAIL rf_data n=%0d got=%0d exp=%0d", n, dr_e, exp_next); end
        exp_next++;
      end
      if (n == 10) begin
        checks++; if (udf_e !== 16'd4 || lvl_e !== 4'd1) begin errors++; $display("FAIL rf_nobypass udf=%0d level=%0d exp 4/1", udf_e, lvl_e); end
      end
    end
    checks++; if (udf_e !== 16'd31) begin errors++; $display("FAIL rf_udf got=%0d exp=31", udf_e); end
    checks++; if (exp_next != 19) begin errors++; $display("FAIL rf_reads got=%0d exp=19", exp_next); end
    kill_e = 1'b0;
    #1;
    checks++; if (udf_e !== 16'd0 || lvl_e !== 4'd0) begin errors++; $display("FAIL rf_kill udf=%0d level=%0d exp 0/0", udf_e, lvl_e); end
  endtask

  task automatic test_saturation();
    kill_d = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 8) begin
        checks++; if (lvl_d !== 4'd8 || full_d !== 1'b1 || ovf_d !== 2'd0)
          begin errors++; $display("FAIL sat_fill level=%0d full=%0b ovf=%0d exp 8/1/0", lvl_d, full_d, ovf_d); end
      end
      if (n == 9) begin
        checks++; if (ovf_d !== 2'd1) begin errors++; $display("FAIL sat_ovf n=9 got=%0d exp=1", ovf_d); end
      end
      if (n >= 11) begin
        checks++; if (ovf_d !== 2'd3) begin errors++; $display("FAIL sat_stick n=%0d got=%0d exp=3", n, ovf_d); end
      end
    end
    checks++; if (udf_d !== 2'd0 || lvl_d !== 4'd8) begin errors++; $display("FAIL sat_end udf=%0d level=%0d exp 0/8", udf_d, lvl_d); end
  endtask

  initial begin
    test_reset();
    test_equal_rate();
    test_write_faster();
    test_run_control();
    test_simul_full();
    test_read_faster();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rate_gen_fifo.md
Name: fifo_rate_gen_fifo

Overview:
Self-contained FIFO exerciser. It contains a write-rate generator, an incrementing data source, a parametrised circular FIFO and a read-rate generator. Width, depth and both strobe periods are parameters, so one module covers the equal-rate and unequal-rate cases. It also reports fill level, full/empty and saturating overflow/underflow counters for board-level bring-up.

Parameters:
DATA_WIDTH, 12, width of generated and read data
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 words (default 8)
WR_EN_PERIOD, 100, clk cycles between write strobes (>=1)
RD_EN_PERIOD, 35, clk cycles between read strobes (>=1)
ERR_CNT_WIDTH, 16, width of overflow/underflow counters

Ports:
clk  in  1  single system clock, rising edge
kill  in  1  reset, asynchronous, active-low
run  in  1  1 = strobe generators count; 0 = generators hold at zero
data_read  out  DATA_WIDTH  last word read from FIFO (registered)
data_valid  out  1  one-cycle pulse when data_read updates
full  out  1  level == 2**DEPTH_LOG2
empty  out  1  level == 0
level  out  DEPTH_LOG2+1  current word count
ovf_cnt  out  ERR_CNT_WIDTH  dropped write strobes, saturating
udf_cnt  out  ERR_CNT_WIDTH  read strobes while empty, saturating

Behaviour:
- Reset:
  - kill=0 asynchronously clears all registers: both period counters, data generator, pointers, level, data_read, data_valid, ovf_cnt, udf_cnt.
  - After reset, empty=1 and full=0.
  - FIFO RAM content is don't-care.
- Strobe generators:
  - Each generator has its own counter, 0..PERIOD-1, advancing while run=1.
  - wr_stb/rd_stb is high for one cycle when the counter equals PERIOD-1; the counter wraps to 0 on the same edge.
  - The first strobe occurs on the PERIOD-th rising edge with run=1. PERIOD=1 gives a strobe every cycle.
  - run=0 forces the counter to 0 with no strobe; FIFO content and counters are retained.
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG2+1 bits wide. The MSB distinguishes full from empty; the low bits address the RAM. Natural binary wrap.
- Write acceptance:
  - Accepted if wr_stb && (!full || rd_accept).
  - Writing when full with a simultaneous read is legal; level stays at 2**DEPTH_LOG2.
  - Accepted write: RAM[wr_ptr] <= gen, wr_ptr++, gen++. gen wraps at 2**DATA_WIDTH.
  - Rejected write: ovf_cnt++ (saturates at all-ones); gen is unchanged. The read sequence is therefore always contiguous.
- Read acceptance:
  - Accepted if rd_stb && !empty. There is no same-cycle bypass: a read when empty fails even if a write is accepted in the same cycle.
  - Failed read: udf_cnt++ (saturating).
  - Accepted read: data_read <= RAM[rd_ptr] on that edge, rd_ptr++, data_valid=1 for the next cycle only. Latency is 1 cycle from strobe to valid.
  - data_read holds its value between reads.
- Level: +1 on write-only, -1 on read-only, unchanged on both or neither. full/empty are decoded from the pointers and must agree with level on every cycle.
- Reset mid-operation: everything returns to the reset state immediately. The first strobe after release takes a full PERIOD again.
- Illegal parameters: PERIOD=0 or DEPTH_LOG2=0 is unsupported; flag it with an elaboration-time error.

Test Plan:
- Equal rates (WR=RD=4, depth 8, run=1 from reset release):
  - First strobe pair hits an empty FIFO: write accepted, udf_cnt=1.
  - From then on level alternates 1/1 (constant 1), ovf_cnt=0.
  - data_read sequence is 0,1,2,… with data_valid every 4 cycles.
- Write faster (WR=2, RD=5, depth 8):
  - level reaches 8 and full=1.
  - Over 200 cycles: ovf_cnt + accepted writes == 100 write strobes.
  - data_read stays contiguous 0,1,2,… with no gaps; udf_cnt=1 at most (first read only if empty, else 0).
- Read faster (WR=5, RD=2):
  - level never exceeds 1, empty=1 most cycles.
  - udf_cnt grows by about 3 per 10 cycles; ovf_cnt=0.
  - Data contiguous.
- Simultaneous at full (WR=1, RD=3, depth 8):
  - After the fill, on every read-strobe cycle with full=1 the write is accepted and level stays 8.
  - On the other cycles ovf_cnt increments by exactly 2 per 3 cycles.
- run/reset control:
  - Deasserting run at level 5 freezes level, pointers and counters.
  - Reasserting run gives the next strobe after a full PERIOD.
  - Asserting kill=0 mid-stream clears level/ovf/udf/data_read to 0 within the same cycle (asynchronous).
- Saturation (ERR_CNT_WIDTH=2, WR=1, RD=100): ovf_cnt sticks at 3 and does not wrap to 0.
